// File: rtl/accelerator_mul_share_arb.sv
// Round-robin arbiter that time-shares one signed x unsigned multiplier among
// NUM_REQ requesters. Stage 1 holds the granted operands, stage 2 holds the
// product. Results return in grant order, tagged with the owning requester.
module accelerator_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int DIN0_WIDTH = 18,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 28
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic                             idle
);

    // Per-requester operand views of the packed input buses
    logic [DIN0_WIDTH-1:0] din0_arr [NUM_REQ];
    logic [DIN1_WIDTH-1:0] din1_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign din0_arr[gi] = req_din0[gi*DIN0_WIDTH +: DIN0_WIDTH];
            assign din1_arr[gi] = req_din1[gi*DIN1_WIDTH +: DIN1_WIDTH];
        end
    endgenerate

    // Pipeline state
    logic                  op_valid_reg;
    logic [DIN0_WIDTH-1:0] op_a_reg;
    logic [DIN1_WIDTH-1:0] op_b_reg;
    logic [ID_W-1:0]       op_id_reg;
    logic                  rsp_valid_reg;
    logic [ID_W-1:0]       rsp_id_reg;
    logic [DOUT_WIDTH-1:0] rsp_dout_reg;
    logic [ID_W-1:0]       rr_ptr_reg;
    logic [ID_W-1:0]       rr_ptr_next;

    // Arbitration results
    logic                  s1_en;
    logic                  s2_en;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_any;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       scan_idx;
    logic                  xfer;

    // Multiplier operands widened to the product width
    logic signed [DOUT_WIDTH-1:0] a_ext;
    logic signed [DOUT_WIDTH-1:0] b_ext;
    logic signed [DOUT_WIDTH-1:0] prod;

    // Stage 2 advances when it is empty or being drained; stage 1 advances
    // when it is empty or can hand its op to stage 2 in the same cycle.
    assign s2_en = ~rsp_valid_reg | rsp_ready;
    assign s1_en = ~op_valid_reg | s2_en;

    // Round-robin search starting at rr_ptr, first requesting index wins
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (s1_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any       = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                end
            end
        end
    end

    // Nobody is accepted while reset is asserted
    assign req_ready = grant & {NUM_REQ{~ap_rst}};
    assign xfer      = grant_any & ~ap_rst;

    // Pointer moves just past the winner; it holds when nothing transfers
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (xfer) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + ID_W'(1);
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Stage 1: capture the granted requester's operands
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            op_valid_reg <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_id_reg    <= '0;
        end else if (xfer) begin
            op_valid_reg <= 1'b1;
            op_a_reg     <= din0_arr[grant_idx];
            op_b_reg     <= din1_arr[grant_idx];
            op_id_reg    <= grant_idx;
        end else if (s1_en) begin
            op_valid_reg <= 1'b0;
        end
    end

    // Operand A is sign-extended, operand B zero-extended, so the low
    // DOUT_WIDTH bits of the product are exact for every input combination.
    assign a_ext = {{(DOUT_WIDTH-DIN0_WIDTH){op_a_reg[DIN0_WIDTH-1]}}, op_a_reg};
    assign b_ext = {{(DOUT_WIDTH-DIN1_WIDTH){1'b0}}, op_b_reg};
    assign prod  = a_ext * b_ext;

    // Stage 2: multiply and register the tagged result; holds under backpressure
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_dout_reg  <= '0;
        end else if (s2_en) begin
            rsp_valid_reg <= op_valid_reg;
            if (op_valid_reg) begin
                rsp_dout_reg <= prod;
                rsp_id_reg   <= op_id_reg;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_dout  = rsp_dout_reg;
    assign idle      = ~op_valid_reg & ~rsp_valid_reg;

endmodule

// File: tb/tb_accelerator_mul_share_arb.sv
// Directed bench for the shared-multiplier arbiter: reset values, latency,
// product boundaries, round-robin order, backpressure and mid-flight reset.
module tb_accelerator_mul_share_arb;

    localparam int NR = 4;
    localparam int W0 = 18;
    localparam int W1 = 10;
    localparam int WO = 28;
    localparam int IW = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W0-1:0]  req_din0;
    logic [NR*W1-1:0]  req_din1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [WO-1:0]     rsp_dout;
    logic              idle;

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-computed products of the standard operand table
    // 0: 3*5=15, 1: -7*9=-63, 2: 100*1000=100000, 3: -2*1023=-2046
    logic [WO-1:0] exp_prod [NR];
    int            exp_q [$];
    int            n_rsp;
    int            exp_id;
    logic [NR-1:0] remaining;
    int            exp_rdy [8];

    accelerator_mul_share_arb #(
        .NUM_REQ(NR), .ID_W(IW), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_din0 (req_din0),
        .req_din1 (req_din1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_dout (rsp_dout),
        .idle     (idle)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_din0[i*W0 +: W0] = W0'(a);
        req_din1[i*W1 +: W1] = W1'(b);
    endtask

    task automatic load_table();
        set_op(0, 3, 5);
        set_op(1, -7, 9);
        set_op(2, 100, 1000);
        set_op(3, -2, 1023);
    endtask

    task automatic check_rsp(input string tag, input int id, input logic [WO-1:0] dout);
        check_val({tag, "_vld"}, 32'(rsp_valid), 1);
        check_val({tag, "_id"}, 32'(rsp_id), id);
        check_val({tag, "_dout"}, 32'(rsp_dout), 32'(dout));
    endtask

    initial begin
        exp_prod[0] = 28'd15;
        exp_prod[1] = 28'hFFFFFC1;
        exp_prod[2] = 28'h00186A0;
        exp_prod[3] = 28'hFFFF802;
        exp_rdy     = '{4, 8, 0, 0, 1, 2, 4, 8};

        ap_rst    = 1'b1;
        rsp_ready = 1'b1;
        req_din0  = '0;
        req_din1  = '0;
        load_table();
        req_valid = 4'hF;

        // Reset state, with all requesters already asking
        #1;
        check_val("rst_ready", 32'(req_ready), 0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 0);
        check_val("rst_idle", 32'(idle), 1);
        check_val("rst_rsp_id", 32'(rsp_id), 0);
        check_val("rst_rsp_dout", 32'(rsp_dout), 0);
        step();
        step();
        ap_rst = 1'b0;
        #1;

        // All four valid from reset: grants 0..3, responses two edges later
        remaining = 4'hF;
        for (int c = 0; c < 4; c++) begin
            req_valid = remaining;
            #1;
            check_val($sformatf("all_ready%0d", c), 32'(req_ready), 32'(1 << c));
            if (c >= 2) check_rsp($sformatf("all_rsp%0d", c - 2), c - 2, exp_prod[c-2]);
            else        check_val($sformatf("all_norsp%0d", c), 32'(rsp_valid), 0);
            step();
            remaining[c] = 1'b0;
        end
        req_valid = '0;
        check_rsp("all_rsp2", 2, exp_prod[2]);
        step();
        check_rsp("all_rsp3", 3, exp_prod[3]);
        step();
        check_val("all_drain_vld", 32'(rsp_valid), 0);
        check_val("all_drain_idle", 32'(idle), 1);

        // Most negative A times largest B
        set_op(0, -131072, 1023);
        req_valid = 4'b0001;
        #1;
        check_val("neg_ready", 32'(req_ready), 1);
        step();
        req_valid = '0;
        step();
        check_rsp("neg_max", 0, 28'h8020000);
        step();

        // Most positive A times largest B, then -1 * 0
        set_op(3, 131071, 1023);
        req_valid = 4'b1000;
        #1;
        check_val("pos_ready", 32'(req_ready), 8);
        step();
        set_op(3, -1, 0);
        #1;
        check_val("zero_ready", 32'(req_ready), 8);
        step();
        req_valid = '0;
        check_rsp("pos_max", 3, 28'h7FDFC01);
        step();
        check_rsp("zero_prod", 3, 28'h0);
        step();
        check_val("c_idle", 32'(idle), 1);

        // Fairness: 0 and 2 alternate; req1 wins once the pointer sits at 1
        load_table();
        req_valid = 4'b0101;
        #1;
        check_val("fair_g0", 32'(req_ready), 1);
        step();
        check_val("fair_g1", 32'(req_ready), 4);
        step();
        check_val("fair_g2", 32'(req_ready), 1);
        step();
        req_valid = 4'b0111;
        #1;
        check_val("fair_g3", 32'(req_ready), 2);
        step();
        req_valid = '0;
        step();
        step();
        step();
        check_val("fair_idle", 32'(idle), 1);

        // Backpressure with a scoreboard of accepted ids
        n_rsp = 0;
        for (int c = 0; c < 10; c++) begin
            rsp_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) check_val($sformatf("bp_ready%0d", c), 32'(req_ready), exp_rdy[c]);
            if (c == 2 || c == 3) check_rsp($sformatf("bp_frozen%0d", c), 2, exp_prod[2]);
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) exp_q.push_back(i);
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    check_val("bp_unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
                end else begin
                    exp_id = exp_q.pop_front();
                    check_val($sformatf("bp_id%0d", n_rsp), 32'(rsp_id), exp_id);
                    check_val($sformatf("bp_dout%0d", n_rsp), 32'(rsp_dout), 32'(exp_prod[exp_id]));
                end
            end
            step();
        end
        check_val("bp_rsp_count", n_rsp, 6);
        check_val("bp_queue_left", exp_q.size(), 0);
        check_val("bp_idle", 32'(idle), 1);

        // Fill both stages from req2 under backpressure, then reset mid-flight
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        check_val("rf_ready0", 32'(req_ready), 4);
        step();
        check_val("rf_ready1", 32'(req_ready), 4);
        step();
        req_valid = 4'b1010;
        #1;
        check_val("rf_full_ready", 32'(req_ready), 0);
        ap_rst = 1'b1;
        #1;
        check_val("rf_async_vld", 32'(rsp_valid), 0);
        check_val("rf_async_idle", 32'(idle), 1);
        check_val("rf_async_dout", 32'(rsp_dout), 0);
        check_val("rf_async_ready", 32'(req_ready), 0);
        step();
        rsp_ready = 1'b1;
        ap_rst    = 1'b0;
        #1;
        check_val("rf_first_grant", 32'(req_ready), 2);
        step();
        req_valid = '0;
        step();
        check_rsp("rf_rsp", 1, exp_prod[1]);
        step();
        check_val("rf_no_stale", 32'(rsp_valid), 0);
        check_val("rf_idle", 32'(idle), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
